// File: rtl/mips_control.sv
// Main decoder and ALU-control unit for a single-cycle MIPS-style datapath.
// Decode is combinational; only pc_write is registered (follows Run by one cycle).
module mips_control (
    input  logic       CLOCK_50,
    input  logic       Reset,
    input  logic [5:0] opcode,
    input  logic       Run,
    output logic       pc_write,
    input  logic [5:0] funct,
    output logic       Regwrite,
    output logic       Aluscr,
    output logic       MemWrite,
    output logic       MemRead,
    output logic       regRead,
    output logic       MemtoReg,
    output logic [3:0] ALUOP,
    output logic       jump,
    output logic       rt_or_rd,
    output logic       brancheq,
    output logic       branchnotequal,
    output logic       branchgreaterthan,
    output logic       branchlessthanorequal,
    output logic       branchgreaterthanorequal,
    output logic       jr,
    output logic       jal,
    output logic       branchlessthan
);

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0011;
    localparam logic [3:0] ALU_NOR  = 4'b0100;
    localparam logic [3:0] ALU_XOR  = 4'b0101;
    localparam logic [3:0] ALU_SLT  = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SUBU = 4'b1001;
    localparam logic [3:0] ALU_ADDU = 4'b1011;

    logic       dec_regwrite, dec_aluscr, dec_memwrite, dec_memread;
    logic       dec_regread, dec_memtoreg, dec_jump, dec_rt_or_rd;
    logic       dec_beq, dec_bne, dec_bgt, dec_ble, dec_bge, dec_blt;
    logic       dec_jr, dec_jal;
    logic [3:0] dec_aluop;

    always_ff @(posedge CLOCK_50 or negedge Reset) begin
        if (!Reset)
            pc_write <= 1'b0;
        else
            pc_write <= Run;
    end

    always_comb begin
        dec_regwrite = 1'b0;
        dec_aluscr   = 1'b0;
        dec_memwrite = 1'b0;
        dec_memread  = 1'b0;
        dec_regread  = 1'b0;
        dec_memtoreg = 1'b0;
        dec_jump     = 1'b0;
        dec_rt_or_rd = 1'b0;
        dec_beq      = 1'b0;
        dec_bne      = 1'b0;
        dec_bgt      = 1'b0;
        dec_ble      = 1'b0;
        dec_bge      = 1'b0;
        dec_blt      = 1'b0;
        dec_jr       = 1'b0;
        dec_jal      = 1'b0;
        dec_aluop    = ALU_AND;
        case (opcode)
            6'b000000: begin
                // Valid arithmetic functs share the same enables; jr and NOP handled apart.
                case (funct)
                    6'b100000: dec_aluop = ALU_ADD;
                    6'b100010: dec_aluop = ALU_SUB;
                    6'b100100: dec_aluop = ALU_AND;
                    6'b100101: dec_aluop = ALU_OR;
                    6'b100111: dec_aluop = ALU_NOR;
                    6'b100110: dec_aluop = ALU_XOR;
                    6'b101010: dec_aluop = ALU_SLT;
                    6'b000000: dec_aluop = ALU_SLL;
                    6'b000010: dec_aluop = ALU_SRL;
                    6'b100011: dec_aluop = ALU_SUBU;
                    6'b100001: dec_aluop = ALU_ADDU;
                    default:   dec_aluop = ALU_AND;
                endcase
                case (funct)
                    6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111, 6'b100110,
                    6'b101010, 6'b000000, 6'b000010, 6'b100011, 6'b100001: begin
                        dec_rt_or_rd = 1'b1;
                        dec_regread  = 1'b1;
                        dec_regwrite = 1'b1;
                    end
                    6'b001001: begin
                        dec_jr      = 1'b1;
                        dec_regread = 1'b1;
                    end
                    default: ;
                endcase
            end
            6'b001000, 6'b001100, 6'b001101: begin
                dec_aluscr   = 1'b1;
                dec_regwrite = 1'b1;
                dec_regread  = 1'b1;
                dec_aluop    = (opcode == 6'b001000) ? ALU_ADD :
                               (opcode == 6'b001100) ? ALU_AND : ALU_OR;
            end
            6'b100011: begin
                dec_aluscr   = 1'b1;
                dec_memread  = 1'b1;
                dec_memtoreg = 1'b1;
                dec_regwrite = 1'b1;
                dec_regread  = 1'b1;
                dec_aluop    = ALU_ADD;
            end
            6'b101011: begin
                dec_aluscr   = 1'b1;
                dec_memwrite = 1'b1;
                dec_regread  = 1'b1;
                dec_aluop    = ALU_ADD;
            end
            6'b000100, 6'b000101, 6'b001111, 6'b110000, 6'b100101, 6'b110001: begin
                dec_regread = 1'b1;
                dec_aluop   = ALU_SUB;
                dec_beq     = (opcode == 6'b000100);
                dec_bne     = (opcode == 6'b000101);
                dec_bgt     = (opcode == 6'b001111);
                dec_blt     = (opcode == 6'b110000);
                dec_ble     = (opcode == 6'b100101);
                dec_bge     = (opcode == 6'b110001);
            end
            6'b000010: dec_jump = 1'b1;
            6'b000011: begin
                // Destination stays rt-select; the datapath forces $31 when jal is set.
                dec_jump     = 1'b1;
                dec_jal      = 1'b1;
                dec_regwrite = 1'b1;
            end
            default: ;
        endcase
    end

    // Reset blanks everything; Run additionally gates the state-changing enables.
    assign Regwrite                 = Reset & Run & dec_regwrite;
    assign MemWrite                 = Reset & Run & dec_memwrite;
    assign MemRead                  = Reset & Run & dec_memread;
    assign Aluscr                   = Reset & dec_aluscr;
    assign regRead                  = Reset & dec_regread;
    assign MemtoReg                 = Reset & dec_memtoreg;
    assign ALUOP                    = Reset ? dec_aluop : 4'b0000;
    assign jump                     = Reset & dec_jump;
    assign rt_or_rd                 = Reset & dec_rt_or_rd;
    assign brancheq                 = Reset & dec_beq;
    assign branchnotequal           = Reset & dec_bne;
    assign branchgreaterthan        = Reset & dec_bgt;
    assign branchlessthanorequal    = Reset & dec_ble;
    assign branchgreaterthanorequal = Reset & dec_bge;
    assign branchlessthan           = Reset & dec_blt;
    assign jr                       = Reset & dec_jr;
    assign jal                      = Reset & dec_jal;

endmodule

// File: tb/tb_mips_control.sv
// Scoreboard bench for mips_control: stimulus pushes expected output vectors,
// a negedge monitor pops and compares them against the DUT.
module tb_mips_control;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       run = 1'b0;
    logic [5:0] op = 6'd0;
    logic [5:0] fn = 6'd0;

    logic       pc_write, Regwrite, Aluscr, MemWrite, MemRead, regRead, MemtoReg;
    logic [3:0] ALUOP;
    logic       jump, rt_or_rd, beq, bne, bgt, ble, bge, jr, jal, blt;

    always #5 clk = ~clk;

    mips_control dut (
        .CLOCK_50(clk), .Reset(rst_n), .opcode(op), .Run(run), .pc_write(pc_write),
        .funct(fn), .Regwrite(Regwrite), .Aluscr(Aluscr), .MemWrite(MemWrite),
        .MemRead(MemRead), .regRead(regRead), .MemtoReg(MemtoReg), .ALUOP(ALUOP),
        .jump(jump), .rt_or_rd(rt_or_rd), .brancheq(beq), .branchnotequal(bne),
        .branchgreaterthan(bgt), .branchlessthanorequal(ble),
        .branchgreaterthanorequal(bge), .jr(jr), .jal(jal), .branchlessthan(blt)
    );

    // Vector layout: {Regwrite,Aluscr,MemWrite,MemRead,regRead,MemtoReg,ALUOP,
    //                 jump,rt_or_rd,beq,bne,bgt,ble,bge,jr,jal,blt,pc_write}
    logic [20:0] actual;
    assign actual = {Regwrite, Aluscr, MemWrite, MemRead, regRead, MemtoReg, ALUOP,
                     jump, rt_or_rd, beq, bne, bgt, ble, bge, jr, jal, blt, pc_write};

    typedef struct {
        logic [20:0] exp;
        string       tag;
    } sb_item_t;

    sb_item_t sb[$];
    int n_cmp = 0;
    int n_err = 0;
    logic model_pc = 1'b0;

    // Reference tables: R-type functs and their ALU codes, branches by opcode.
    logic [5:0] r_fn  [11] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111,
                               6'b100110, 6'b101010, 6'b000000, 6'b000010, 6'b100011, 6'b100001};
    logic [3:0] r_alu [11] = '{4'd2, 4'd3, 4'd0, 4'd1, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd11};
    // Branch order matches flag order beq,bne,bgt,ble,bge,blt in the vector.
    logic [5:0] br_op [6]  = '{6'b000100, 6'b000101, 6'b001111, 6'b100101, 6'b110001, 6'b110000};

    function automatic logic [20:0] ref_model(input logic r_n, input logic rn,
                                              input logic [5:0] o, input logic [5:0] f,
                                              input logic pc);
        logic rw, sc, mw, mr, rr, m2r, jp, rd, j_r, j_l;
        logic [3:0] alu;
        logic [5:0] br;
        {rw, sc, mw, mr, rr, m2r, jp, rd, j_r, j_l} = '0;
        alu = 4'd0;
        br  = 6'd0;
        if (o == 6'd0) begin
            for (int i = 0; i < 11; i++)
                if (f == r_fn[i]) begin
                    alu = r_alu[i]; rw = 1; rr = 1; rd = 1;
                end
            if (f == 6'b001001) begin
                j_r = 1; rr = 1;
            end
        end else if (o == 6'b001000) begin sc = 1; rw = 1; rr = 1; alu = 4'd2; end
        else if (o == 6'b001100) begin sc = 1; rw = 1; rr = 1; alu = 4'd0; end
        else if (o == 6'b001101) begin sc = 1; rw = 1; rr = 1; alu = 4'd1; end
        else if (o == 6'b100011) begin sc = 1; mr = 1; m2r = 1; rw = 1; rr = 1; alu = 4'd2; end
        else if (o == 6'b101011) begin sc = 1; mw = 1; rr = 1; alu = 4'd2; end
        else if (o == 6'b000010) begin jp = 1; end
        else if (o == 6'b000011) begin jp = 1; j_l = 1; rw = 1; end
        else begin
            for (int i = 0; i < 6; i++)
                if (o == br_op[i]) begin
                    br[5-i] = 1'b1; rr = 1; alu = 4'd3;
                end
        end
        if (!rn) begin rw = 0; mw = 0; mr = 0; end
        if (!r_n) return 21'd0;
        return {rw, sc, mw, mr, rr, m2r, alu, jp, rd, br[5:1], j_r, j_l, br[0], pc};
    endfunction

    // One stimulus per cycle: update the PC-enable model at the edge, then drive.
    task automatic apply(input logic r_n, input logic rn, input logic [5:0] o,
                         input logic [5:0] f, input string tag);
        sb_item_t it;
        @(posedge clk);
        model_pc = rst_n ? run : 1'b0;
        #2;
        rst_n = r_n; run = rn; op = o; fn = f;
        if (!r_n) model_pc = 1'b0;
        it.exp = ref_model(r_n, rn, o, f, model_pc);
        it.tag = tag;
        sb.push_back(it);
    endtask

    initial begin : monitor
        sb_item_t it;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                it = sb.pop_front();
                n_cmp++;
                if (actual !== it.exp) begin
                    n_err++;
                    $display("FAIL %s: got %b expected %b (op=%b fn=%b run=%b rst_n=%b)",
                             it.tag, actual, it.exp, op, fn, run, rst_n);
                end
            end
        end
    end

    initial begin : stim
        logic [5:0] ops [17] = '{6'b000000, 6'b001000, 6'b001100, 6'b001101, 6'b100011,
                                 6'b101011, 6'b000100, 6'b000101, 6'b001111, 6'b110000,
                                 6'b100101, 6'b110001, 6'b000010, 6'b000011, 6'b111111,
                                 6'b000000, 6'b000000};
        logic [5:0] o, f;
        logic r_n, rn;
        int wait_cyc;

        for (int i = 0; i < 3; i++) apply(1'b0, 1'b1, 6'b000000, 6'b100000, "reset_hold");
        apply(1'b1, 1'b1, 6'b000000, 6'b100000, "reset_release");
        for (int i = 0; i < 11; i++) apply(1'b1, 1'b1, 6'b000000, r_fn[i], "rtype");
        apply(1'b1, 1'b1, 6'b000000, 6'b001001, "jr");
        apply(1'b1, 1'b1, 6'b000000, 6'b111111, "rtype_nop");
        for (int i = 1; i < 15; i++) apply(1'b1, 1'b1, ops[i], 6'b100000, "itype_branch_jump");
        apply(1'b1, 0, 6'b100011, 6'b000000, "run_gate_lw");
        apply(1'b1, 0, 6'b100011, 6'b000000, "run_gate_pc_fall");
        apply(1'b1, 1'b1, 6'b101011, 6'b000000, "run_resume_sw");
        apply(1'b0, 1'b1, 6'b100011, 6'b000000, "reset_midrun");
        apply(1'b1, 1'b1, 6'b000011, 6'b000000, "after_reset_jal");

        for (int i = 0; i < 400; i++) begin
            r_n = ($urandom_range(0, 15) != 0);
            rn  = ($urandom_range(0, 3) != 0);
            o   = ($urandom_range(0, 3) == 0) ? 6'($urandom) : ops[$urandom_range(0, 16)];
            f   = ($urandom_range(0, 3) == 0) ? 6'($urandom)
                : (($urandom_range(0, 7) == 0) ? 6'b001001 : r_fn[$urandom_range(0, 10)]);
            apply(r_n, rn, o, f, "random");
        end

        wait_cyc = 0;
        while (sb.size() > 0 && wait_cyc < 10) begin
            @(posedge clk);
            wait_cyc++;
        end
        if (sb.size() > 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
